mc_control_fsm: RTL
===================

# mc_control_fsm

Parametrised multi-cycle control sequencer for the 32-bit MIPS-subset core. It replaces the fixed-latency control unit and drives the same datapath select and enable signals. It adds four things: a memory ready handshake with wait states, `bne`, a sticky halt/illegal-opcode trap, and a retired-instruction counter. It sits beside the datapath in the CPU top; the top forms `pc_en = PCWrite | (Branch & zero) | (BranchNe & ~zero)`.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 means memory strobes wait for `mem_ready`; 0 means `mem_ready` is ignored and treated as 1.
- `ALUCTL_W`, default 4: width of `ALUControl`.
- `CNT_W`, default 32: width of `retired`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Opcode`  in  6  IR[31:26].
- `Funct`  in  6  IR[5:0].
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access requested.
- `IorD`  out  1  address select: 0 = PC, 1 = ALU-out register.
- `MemWrite`, `IRWrite`, `PCWrite`, `RegWrite`  out  1 each  write enables.
- `Branch`, `BranchNe`  out  1 each  conditional PC enable, taken on zero / not zero.
- `PCSrc`  out  2  00 = ALU result, 01 = ALU-out register, 10 = jump target.
- `ALUSrcA`  out  1  0 = PC, 1 = A.
- `ALUSrcB`  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `ALUControl`  out  ALUCTL_W  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- `Mem2Reg`  out  1  1 = memory data register.
- `RegDst`  out  1  1 = rd (IR[15:11]), 0 = rt.
- `halted`  out  1  sticky; asserted in HALT or ILLEGAL.
- `illegal`  out  1  sticky; asserted in ILLEGAL only.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- Moore FSM. All outputs decode from the state register, except the handshake-gated strobes, which also depend on `mem_ready`. Any output not listed for a state is 0.
- FETCH:
  - Outputs: `mem_req=1`, `IorD=0`, `ALUSrcA=0`, `ALUSrcB=01`, add, `PCSrc=00`.
  - `IRWrite` and `PCWrite` are 1 only while `mem_ready=1`. The FSM stays in FETCH until then, then goes to DECODE.
- DECODE:
  - Outputs: `ALUSrcA=0`, `ALUSrcB=11`, add (precomputes the branch target).
  - Next state by opcode: 100011 or 101011 → MEMADR; 000000 → EXEC; 001000 → ADDIEX; 000100 or 000101 → BRANCH; 000010 → JUMP; 111111 → HALT; anything else → ILLEGAL.
- MEMADR: `ALUSrcA=1`, `ALUSrcB=10`, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_req=1`, `IorD=1`. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `RegWrite=1`, `Mem2Reg=1`, `RegDst=0`. Next state FETCH.
- MEMWR: `mem_req=1`, `IorD=1`. `MemWrite` is 1 only while `mem_ready=1`. Waits for `mem_ready`, then goes to FETCH.
- EXEC:
  - Outputs: `ALUSrcA=1`, `ALUSrcB=00`, ALU operation from `Funct`.
  - Funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - An unknown funct → ILLEGAL; no register write happens.
  - Known funct → ALUWB.
- ALUWB: `RegWrite=1`, `RegDst=1`, `Mem2Reg=0`. Next state FETCH.
- ADDIEX: `ALUSrcA=1`, `ALUSrcB=10`, add. Next state ADDIWB.
- ADDIWB: `RegWrite=1`, `RegDst=0`, `Mem2Reg=0`. Next state FETCH.
- BRANCH:
  - Outputs: `ALUSrcA=1`, `ALUSrcB=00`, sub, `PCSrc=01`.
  - `Branch=1` for opcode 000100; `BranchNe=1` for opcode 000101.
  - Next state FETCH.
- JUMP: `PCWrite=1`, `PCSrc=10`. Next state FETCH.
- HALT and ILLEGAL are absorbing: every enable is 0, and only reset leaves them.
- `retired` increments by 1, wrapping modulo 2^CNT_W, on each transition into FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP. HALT and ILLEGAL are not counted.

## Timing
- While `rst_n=0`, state is FETCH, `retired=0`, and every output is 0. Reset asserted in the middle of an instruction takes effect immediately and abandons any access in progress.
- The first `mem_req` is asserted in the first cycle after `rst_n` rises.
- Latency with zero wait states: R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3 cycles. Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds 1 cycle.
- `mem_req` stays high and `IorD` stays stable throughout a wait.
- `MEM_HANDSHAKE=0` gives exactly the zero-wait latencies regardless of `mem_ready`.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - opcode and funct localparams;
  - ALUControl codes;
  - PCSrc and ALUSrcB encodings.
- Split into two processes: a state and counter register process, and a combinational next-state/output decode.
- Optional sub-module `mc_alu_decode`, a combinational Funct→ALUControl map that also produces a valid flag.

## Test plan
- Reset: hold `rst_n=0` and toggle `clk` → all outputs 0, `retired=0`. After release, cycle 1 shows `mem_req=1`, `IorD=0`, `ALUSrcB=01`.
- R-type add (Opcode 000000, Funct 100000), `mem_ready=1` → ALUWB in cycle 4 with `RegWrite=1`, `RegDst=1`; `retired` goes 0→1.
- lw with `mem_ready` low for 2 cycles in MEMRD → `mem_req` and `IorD=1` held for 3 cycles; MEMWB in cycle 7 with `Mem2Reg=1`.
- beq and bne → in cycle 3, `Branch`=1/0 and `BranchNe`=0/1 respectively, with ALUControl 0110 and `PCSrc=01`.
- Opcode 111111 → `halted=1`, `illegal=0`, and `retired` frozen for 20 cycles. Opcode 010101 → `illegal=1`. Each then returns to FETCH only after a reset pulse.
- `MEM_HANDSHAKE=0` with `mem_ready` tied 0 → sw completes in 4 cycles, `MemWrite` pulsed for 1 cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS-subset control sequencer.
//   - state_t and the FSM state constants (plain localparams so the encoding
//     stays fixed and visible in waveforms)
//   - opcode / funct field values
//   - ALUControl, PCSrc and ALUSrcB encodings
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH   = 4'd0;
  localparam state_t S_DECODE  = 4'd1;
  localparam state_t S_MEMADR  = 4'd2;
  localparam state_t S_MEMRD   = 4'd3;
  localparam state_t S_MEMWB   = 4'd4;
  localparam state_t S_MEMWR   = 4'd5;
  localparam state_t S_EXEC    = 4'd6;
  localparam state_t S_ALUWB   = 4'd7;
  localparam state_t S_ADDIEX  = 4'd8;
  localparam state_t S_ADDIWB  = 4'd9;
  localparam state_t S_BRANCH  = 4'd10;
  localparam state_t S_JUMP    = 4'd11;
  localparam state_t S_HALT    = 4'd12;
  localparam state_t S_ILLEGAL = 4'd13;

  // Opcode field, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Funct field, IR[5:0], for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Native ALU operation codes; the top zero-extends to ALUCTL_W
  localparam int         ALU_CODE_W = 4;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: combinational R-type Funct -> ALU operation map.
// Ports:
//   funct    in  6  IR[5:0]
//   alu_ctl  out 4  ALU operation code (0000 when funct is unknown)
//   valid    out 1  funct is one of add/sub/and/or/slt
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl,
  output logic       valid
);

  always_comb begin
    alu_ctl = 4'b0000;
    valid   = 1'b1;
    case (funct)
      FN_ADD:  alu_ctl = ALU_ADD;
      FN_SUB:  alu_ctl = ALU_SUB;
      FN_AND:  alu_ctl = ALU_AND;
      FN_OR:   alu_ctl = ALU_OR;
      FN_SLT:  alu_ctl = ALU_SLT;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle Moore control sequencer for the MIPS-subset core.
// Parameters:
//   MEM_HANDSHAKE  1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready ignored
//   ALUCTL_W       width of ALUControl
//   CNT_W          width of the retired-instruction counter
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   Opcode, Funct        instruction fields from the IR
//   mem_ready            memory finishes the current access this cycle
//   mem_req, IorD        memory request and address select
//   MemWrite, IRWrite, PCWrite, RegWrite, Branch, BranchNe   enables
//   PCSrc, ALUSrcA, ALUSrcB, ALUControl, Mem2Reg, RegDst    datapath selects
//   halted, illegal      sticky trap status
//   retired              completed-instruction count (wraps)
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ALUCTL_W      = 4,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          Opcode,
  input  logic [5:0]          Funct,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                Branch,
  output logic                BranchNe,
  output logic [1:0]          PCSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                Mem2Reg,
  output logic                RegDst,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;

  logic       ready_eff;
  logic       retire_c;
  logic       mem_req_c, iord_c, memwrite_c, irwrite_c, pcwrite_c, regwrite_c;
  logic       branch_c, branchne_c, alusrca_c, mem2reg_c, regdst_c;
  logic [1:0] pcsrc_c, alusrcb_c;
  logic [3:0] alu_ctl_c;
  logic [3:0] fn_alu_ctl;
  logic       fn_valid;

  logic [ALUCTL_W-1:0] alu_ext;

  assign ready_eff = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

  mc_alu_decode u_alu_decode (
    .funct   (Funct),
    .alu_ctl (fn_alu_ctl),
    .valid   (fn_valid)
  );

  // State and retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire_c) begin
        retired_reg <= retired_reg + CNT_W'(1);
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next = state_reg;
    retire_c   = 1'b0;
    mem_req_c  = 1'b0;
    iord_c     = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    branch_c   = 1'b0;
    branchne_c = 1'b0;
    pcsrc_c    = PCSRC_ALU;
    alusrca_c  = 1'b0;
    alusrcb_c  = SRCB_B;
    alu_ctl_c  = 4'b0000;
    mem2reg_c  = 1'b0;
    regdst_c   = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alusrcb_c = SRCB_FOUR;
        alu_ctl_c = ALU_ADD;
        if (ready_eff) begin
          irwrite_c  = 1'b1;
          pcwrite_c  = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes PC+4 + (imm<<2) so BRANCH can use ALU-out.
        alusrcb_c = SRCB_IMMSH;
        alu_ctl_c = ALU_ADD;
        case (Opcode)
          OP_LW, OP_SW:   state_next = S_MEMADR;
          OP_RTYPE:       state_next = S_EXEC;
          OP_ADDI:        state_next = S_ADDIEX;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_J:           state_next = S_JUMP;
          OP_HALT:        state_next = S_HALT;
          default:        state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca_c  = 1'b1;
        alusrcb_c  = SRCB_IMM;
        alu_ctl_c  = ALU_ADD;
        state_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (ready_eff) begin
          state_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        mem2reg_c  = 1'b1;
        state_next = S_FETCH;
        retire_c   = 1'b1;
      end
      S_MEMWR: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (ready_eff) begin
          memwrite_c = 1'b1;
          state_next = S_FETCH;
          retire_c   = 1'b1;
        end
      end
      S_EXEC: begin
        alusrca_c  = 1'b1;
        alu_ctl_c  = fn_alu_ctl;
        // Unknown funct traps before any register write.
        state_next = fn_valid ? S_ALUWB : S_ILLEGAL;
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
        state_next = S_FETCH;
        retire_c   = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_c  = 1'b1;
        alusrcb_c  = SRCB_IMM;
        alu_ctl_c  = ALU_ADD;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        state_next = S_FETCH;
        retire_c   = 1'b1;
      end
      S_BRANCH: begin
        alusrca_c  = 1'b1;
        alu_ctl_c  = ALU_SUB;
        pcsrc_c    = PCSRC_ALUOUT;
        branch_c   = (Opcode == OP_BEQ);
        branchne_c = (Opcode == OP_BNE);
        state_next = S_FETCH;
        retire_c   = 1'b1;
      end
      S_JUMP: begin
        pcwrite_c  = 1'b1;
        pcsrc_c    = PCSRC_JUMP;
        state_next = S_FETCH;
        retire_c   = 1'b1;
      end
      S_HALT:    state_next = S_HALT;
      S_ILLEGAL: state_next = S_ILLEGAL;
      // Unused encodings trap rather than wander.
      default:   state_next = S_ILLEGAL;
    endcase
  end

  generate
    if (ALUCTL_W > ALU_CODE_W) begin : g_aluctl_wide
      assign alu_ext = {{(ALUCTL_W-ALU_CODE_W){1'b0}}, alu_ctl_c};
    end else begin : g_aluctl_narrow
      assign alu_ext = alu_ctl_c[ALUCTL_W-1:0];
    end
  endgenerate

  // Outputs are forced low combinationally while reset is held, so FETCH's
  // mem_req does not leak out before rst_n rises.
  assign mem_req    = rst_n & mem_req_c;
  assign IorD       = rst_n & iord_c;
  assign MemWrite   = rst_n & memwrite_c;
  assign IRWrite    = rst_n & irwrite_c;
  assign PCWrite    = rst_n & pcwrite_c;
  assign RegWrite   = rst_n & regwrite_c;
  assign Branch     = rst_n & branch_c;
  assign BranchNe   = rst_n & branchne_c;
  assign PCSrc      = rst_n ? pcsrc_c : 2'b00;
  assign ALUSrcA    = rst_n & alusrca_c;
  assign ALUSrcB    = rst_n ? alusrcb_c : 2'b00;
  assign ALUControl = rst_n ? alu_ext : '0;
  assign Mem2Reg    = rst_n & mem2reg_c;
  assign RegDst     = rst_n & regdst_c;
  assign halted     = rst_n & ((state_reg == S_HALT) | (state_reg == S_ILLEGAL));
  assign illegal    = rst_n & (state_reg == S_ILLEGAL);
  assign retired    = retired_reg;

endmodule
